// File: rtl/onehot_scan_decoder_pkg.sv
// Shared encodings for the one-hot scan decoder: FSM states and the meaning of the mode input.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic isActive(state_e s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control inputs and select-line outputs of the one-hot scan decoder, grouped for the display path.
interface onehot_scan_decoder_if #(
  parameter int SEL_W = 3
) ();

  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] dout;
  logic [SEL_W-1:0] idx;
  logic             valid;
  logic             wrap;

  modport master (
    output en, mode, sel,
    input  dout, idx, valid, wrap
  );

  modport slave (
    input  en, mode, sel,
    output dout, idx, valid, wrap
  );

endinterface

// File: rtl/onehot_scan_decoder_tick_gen.sv
// Prescaler for scan stepping: tick is high for one clock out of every PRESCALE, clr restarts the count.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a prescaled scan mode for multiplexing display digits.
module onehot_scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_scan_decoder_if.slave bus
);

  import decoder_pkg::*;

  localparam int OUT_W = 2 ** SEL_W;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] hot_q, hot_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             scanClr;
  logic             scanStep;

  // Prescaler only runs while scanning steadily; entering or leaving SCAN restarts it.
  assign scanClr  = (state_q != SCAN) || (state_d != SCAN);
  assign scanStep = !scanClr && tick;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (scanClr),
    .tick (tick)
  );

  always_comb begin
    state_d = IDLE;
    if (bus.en) begin
      state_d = (bus.mode == MODE_DIRECT) ? DIRECT : SCAN;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (state_d == DIRECT || (state_d == SCAN && state_q != SCAN)) begin
      idx_d = bus.sel;
    end else if (scanStep) begin
      idx_d  = idx_q + SEL_W'(1);
      wrap_d = (idx_q == {SEL_W{1'b1}});
    end
    valid_d = isActive(state_d);
    hot_d   = valid_d ? (OUT_W'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hot_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hot_q   <= hot_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  // hot_q is always active-high internally; the board polarity is applied only here.
  assign bus.dout  = ACTIVE_LOW ? ~hot_q : hot_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Bench for onehot_scan_decoder: three instances (default, active-low, PRESCALE=1/SEL_W=2) against a line-schedule model.
module tb_onehot_scan_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  onehot_scan_decoder_if #(.SEL_W(3)) busA ();
  onehot_scan_decoder_if #(.SEL_W(3)) busL ();
  onehot_scan_decoder_if #(.SEL_W(2)) busP ();

  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dutL (.clk(clk), .rst_n(rst_n), .bus(busL));
  onehot_scan_decoder #(.SEL_W(2), .PRESCALE(1), .ACTIVE_LOW(1'b0)) dutP (.clk(clk), .rst_n(rst_n), .bus(busP));

  always #5 clk = ~clk;

  // Model 0 covers busA/busL (8 lines, 4 clocks per line), model 1 covers busP (4 lines, 1 clock per line).
  // In scan, the active line is start + (clocks since entry / PRESCALE), modulo the line count.
  int mScan[2], mStart[2], mN[2], mIdx[2], mValid[2], mWrap[2], mHot[2];

  task automatic modelReset(input int m);
    mScan[m] = 0; mStart[m] = 0; mN[m] = 0;
    mIdx[m] = 0; mValid[m] = 0; mWrap[m] = 0; mHot[m] = 0;
  endtask

  task automatic modelEdge(input int m, input logic en, input logic mode, input int sel,
                           input int presc, input int lines);
    mWrap[m] = 0;
    if (!en) begin
      mScan[m] = 0; mValid[m] = 0; mHot[m] = 0;
    end else begin
      if (!mode) begin
        mScan[m] = 0;
        mIdx[m]  = sel;
      end else begin
        if (mScan[m] == 0) begin
          mScan[m] = 1; mStart[m] = sel; mN[m] = 0;
        end else begin
          mN[m]++;
        end
        mIdx[m]  = (mStart[m] + mN[m] / presc) % lines;
        mWrap[m] = (mN[m] > 0 && mN[m] % presc == 0 && mIdx[m] == 0) ? 1 : 0;
      end
      mValid[m] = 1;
      mHot[m]   = 1 << mIdx[m];
    end
  endtask

  function automatic logic [12:0] expA();
    return {8'(mHot[0]), 3'(mIdx[0]), 1'(mValid[0]), 1'(mWrap[0])};
  endfunction
  function automatic logic [12:0] expL();
    return {~8'(mHot[0]), 3'(mIdx[0]), 1'(mValid[0]), 1'(mWrap[0])};
  endfunction
  function automatic logic [7:0] expP();
    return {4'(mHot[1]), 2'(mIdx[1]), 1'(mValid[1]), 1'(mWrap[1])};
  endfunction
  function automatic logic [12:0] obsA();
    return {busA.dout, busA.idx, busA.valid, busA.wrap};
  endfunction
  function automatic logic [12:0] obsL();
    return {busL.dout, busL.idx, busL.valid, busL.wrap};
  endfunction
  function automatic logic [7:0] obsP();
    return {busP.dout, busP.idx, busP.valid, busP.wrap};
  endfunction

  task automatic driveA(input logic en, input logic mode, input int sel);
    busA.en = en; busA.mode = mode; busA.sel = 3'(sel);
    busL.en = en; busL.mode = mode; busL.sel = 3'(sel);
  endtask

  task automatic driveP(input logic en, input logic mode, input int sel);
    busP.en = en; busP.mode = mode; busP.sel = 2'(sel);
  endtask

  task automatic clockEdge();
    @(posedge clk);
    if (!rst_n) begin
      modelReset(0); modelReset(1);
    end else begin
      modelEdge(0, busA.en, busA.mode, int'(busA.sel), 4, 8);
      modelEdge(1, busP.en, busP.mode, int'(busP.sel), 1, 4);
    end
    #1;
  endtask

  task automatic test_reset();
    driveA(1'b0, 1'b0, 0);
    driveP(1'b0, 1'b0, 0);
    #2 rst_n = 1'b0;
    modelReset(0); modelReset(1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busA.dout !== 8'h00 || busA.valid !== 1'b0 || busA.idx !== 3'd0 || busA.wrap !== 1'b0) begin
      bad++; $display("[TB] FAIL resetA got=%h want=%h", obsA(), 13'h0000);
    end
    total++;
    if (busL.dout !== 8'hFF || busL.valid !== 1'b0 || busL.idx !== 3'd0 || busL.wrap !== 1'b0) begin
      bad++; $display("[TB] FAIL resetL got=%h want=%h", obsL(), {8'hFF, 5'h00});
    end
    total++;
    if (obsP() !== 8'h00) begin
      bad++; $display("[TB] FAIL resetP got=%h want=%h", obsP(), 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clockEdge();
    total++;
    if (obsA() !== expA()) begin
      bad++; $display("[TB] FAIL idleAfterReset got=%h want=%h", obsA(), expA());
    end
  endtask

  task automatic test_direct_sweep();
    for (int s = 0; s < 8; s++) begin
      driveA(1'b1, 1'b0, s);
      clockEdge();
      total++;
      if (busA.dout !== (8'h01 << s) || busA.valid !== 1'b1 || obsA() !== expA()) begin
        bad++; $display("[TB] FAIL direct sel=%0d got=%h want=%h", s, obsA(), expA());
      end
      total++;
      if (obsL() !== expL()) begin
        bad++; $display("[TB] FAIL directL sel=%0d got=%h want=%h", s, obsL(), expL());
      end
      clockEdge();
      total++;
      if (obsA() !== expA()) begin
        bad++; $display("[TB] FAIL directHold sel=%0d got=%h want=%h", s, obsA(), expA());
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] wantDout;
    driveA(1'b1, 1'b1, 6);
    for (int k = 0; k < 12; k++) begin
      clockEdge();
      wantDout = (k < 4) ? 8'h40 : (k < 8) ? 8'h80 : 8'h01;
      total++;
      if (busA.dout !== wantDout || busA.wrap !== 1'(k == 8) || obsA() !== expA()) begin
        bad++; $display("[TB] FAIL scan k=%0d got=%h want=%h", k, obsA(), expA());
      end
      total++;
      if (obsL() !== expL()) begin
        bad++; $display("[TB] FAIL scanL k=%0d got=%h want=%h", k, obsL(), expL());
      end
    end
  endtask

  task automatic test_disable();
    driveA(1'b0, 1'b0, 0);
    clockEdge();
    driveA(1'b1, 1'b1, 0);
    repeat (13) clockEdge();
    total++;
    if (busA.idx !== 3'd3 || obsA() !== expA()) begin
      bad++; $display("[TB] FAIL scanToIdx3 got=%h want=%h", obsA(), expA());
    end
    driveA(1'b0, 1'b1, 0);
    clockEdge();
    total++;
    if (busA.dout !== 8'h00 || busA.valid !== 1'b0 || busA.idx !== 3'd3 || obsA() !== expA()) begin
      bad++; $display("[TB] FAIL disable got=%h want=%h", obsA(), expA());
    end
    total++;
    if (busL.dout !== 8'hFF || obsL() !== expL()) begin
      bad++; $display("[TB] FAIL disableL got=%h want=%h", obsL(), expL());
    end
    driveA(1'b1, 1'b1, 5);
    clockEdge();
    total++;
    if (busA.dout !== 8'h20 || obsA() !== expA()) begin
      bad++; $display("[TB] FAIL reenter got=%h want=%h", obsA(), expA());
    end
  endtask

  task automatic test_prescale1();
    driveP(1'b1, 1'b1, 0);
    for (int k = 0; k < 9; k++) begin
      clockEdge();
      total++;
      if (busP.dout !== 4'(1 << (k % 4)) || busP.wrap !== 1'(k > 0 && k % 4 == 0) || obsP() !== expP()) begin
        bad++; $display("[TB] FAIL prescale1 k=%0d got=%h want=%h", k, obsP(), expP());
      end
    end
    driveP(1'b0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    repeat (3) clockEdge();
    #3 rst_n = 1'b0;
    modelReset(0); modelReset(1);
    #1;
    total++;
    if (busA.dout !== 8'h00 || busA.valid !== 1'b0 || busA.idx !== 3'd0 || busA.wrap !== 1'b0) begin
      bad++; $display("[TB] FAIL asyncResetA got=%h want=%h", obsA(), 13'h0000);
    end
    total++;
    if (busL.dout !== 8'hFF || busL.valid !== 1'b0) begin
      bad++; $display("[TB] FAIL asyncResetL got=%h want=%h", obsL(), {8'hFF, 5'h00});
    end
    driveA(1'b1, 1'b0, 2);
    #2 rst_n = 1'b1;
    clockEdge();
    total++;
    if (busA.dout !== 8'h04 || busA.valid !== 1'b1 || obsA() !== expA()) begin
      bad++; $display("[TB] FAIL releaseDirect got=%h want=%h", obsA(), expA());
    end
  endtask

  task automatic test_random();
    logic aEn = 1'b1, aMode = 1'b1, pEn = 1'b1, pMode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        aEn = ($urandom_range(0, 4) != 0); aMode = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) begin
        pEn = ($urandom_range(0, 4) != 0); pMode = 1'($urandom_range(0, 1));
      end
      driveA(aEn, aMode, int'($urandom_range(0, 7)));
      driveP(pEn, pMode, int'($urandom_range(0, 3)));
      clockEdge();
      total++;
      if (obsA() !== expA()) begin
        bad++; $display("[TB] FAIL randomA i=%0d got=%h want=%h", i, obsA(), expA());
      end
      total++;
      if (obsL() !== expL()) begin
        bad++; $display("[TB] FAIL randomL i=%0d got=%h want=%h", i, obsL(), expL());
      end
      total++;
      if (obsP() !== expP()) begin
        bad++; $display("[TB] FAIL randomP i=%0d got=%h want=%h", i, obsP(), expP());
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_sweep();
    test_scan();
    test_disable();
    test_prescale1();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
